execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 184 ++++++++++++++++++
 tb/tb_execute_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative 16x16 signed multiply,
// with registered result and memory-access controls for the next stage.
module execute_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DATA_A = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [31:0]       operand_a,
  input  logic [31:0]       operand_b,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  output logic [31:0]       result,
  output logic              out_valid,
  output logic              overflow,
  output logic [DATA_A-1:0] datamem_address,
  output logic [DATA_W-1:0] datamem_data,
  output logic              ctr_datamem_MR,
  output logic              ctr_datamem_MW,
  output logic              busy
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned MUL_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [3:0]  OP_MUL = 4'd9;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic [DATA_A-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               mr_q, mr_d;
  logic               mw_q, mw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    mcand_q, mcand_d;
  logic [MUL_W-1:0]   mplr_q, mplr_d;
  logic [DATA_W-1:0]  store_q, store_d;

  logic [XLEN-1:0]    alu_res;
  logic               alu_ovf;
  logic [XLEN-1:0]    partial;
  logic [XLEN-1:0]    acc_next;

  // Single-cycle ALU; overflow only meaningful for ADD/SUB
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op)
      4'd0: begin
        alu_res = operand_a + operand_b;
        alu_ovf = (operand_a[31] == operand_b[31]) && (alu_res[31] != operand_a[31]);
      end
      4'd1: begin
        alu_res = operand_a - operand_b;
        alu_ovf = (operand_a[31] != operand_b[31]) && (alu_res[31] != operand_a[31]);
      end
      4'd2:  alu_res = operand_a & operand_b;
      4'd3:  alu_res = operand_a | operand_b;
      4'd4:  alu_res = operand_a ^ operand_b;
      4'd5:  alu_res = XLEN'($signed(operand_a) < $signed(operand_b));
      4'd6:  alu_res = operand_a << operand_b[4:0];
      4'd7:  alu_res = operand_a >> operand_b[4:0];
      4'd8:  alu_res = XLEN'($signed(operand_a) >>> operand_b[4:0]);
      4'd10: alu_res = operand_b;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step; the multiplier MSB carries negative weight (signed operand)
  always_comb begin
    partial  = mplr_q[0] ? mcand_q : '0;
    acc_next = (cnt_q == CNT_W'(MUL_W - 1)) ? (acc_q - partial) : (acc_q + partial);
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mr_d        = mr_q;
    mw_d        = mw_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    store_d     = store_q;
    if (enable) begin
      out_valid_d = 1'b0;
      mr_d        = 1'b0;
      mw_d        = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_d = MUL;
              mcand_d = XLEN'($signed(operand_a[MUL_W-1:0]));
              mplr_d  = operand_b[MUL_W-1:0];
              cnt_d   = '0;
              acc_d   = '0;
              store_d = store_data;
            end else begin
              result_d    = alu_res;
              overflow_d  = alu_ovf;
              out_valid_d = 1'b1;
              addr_d      = alu_res[DATA_A-1:0];
              data_d      = store_data;
              mr_d        = mem_read_in & ~mem_write_in;
              mw_d        = mem_write_in & ~mem_read_in;
            end
          end
        end
        MUL: begin
          acc_d   = acc_next;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_W - 1)) begin
            state_d     = IDLE;
            result_d    = acc_next;
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
            addr_d      = acc_next[DATA_A-1:0];
            data_d      = store_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      store_q     <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      store_q     <= store_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign busy            = (state_q == MUL);
  assign result          = result_q;
  assign out_valid       = out_valid_q;
  assign overflow        = overflow_q;
  assign datamem_address = addr_q;
  assign datamem_data    = data_q;
  assign ctr_datamem_MR  = mr_q;
  assign ctr_datamem_MW  = mw_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expected values.
module tb_execute_stage;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DATA_A = 11;

  logic              clk = 1'b0;
  logic              reset, enable, in_valid, in_ready;
  logic [3:0]        op;
  logic [31:0]       operand_a, operand_b;
  logic [DATA_W-1:0] store_data;
  logic              mem_read_in, mem_write_in;
  logic [31:0]       result;
  logic              out_valid, overflow;
  logic [DATA_A-1:0] datamem_address;
  logic [DATA_W-1:0] datamem_data;
  logic              ctr_datamem_MR, ctr_datamem_MW, busy;

  int passed = 0;
  int total  = 0;

  execute_stage #(.DATA_W(DATA_W), .DATA_A(DATA_A)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .store_data(store_data), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .result(result), .out_valid(out_valid), .overflow(overflow),
    .datamem_address(datamem_address), .datamem_data(datamem_data),
    .ctr_datamem_MR(ctr_datamem_MR), .ctr_datamem_MW(ctr_datamem_MW), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] sd,
                       input logic mr, input logic mw);
    in_valid = v; op = o; operand_a = a; operand_b = b;
    store_data = sd; mem_read_in = mr; mem_write_in = mw;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_addr"}, 32'(datamem_address), 32'd0);
    chk({tag, "_data"}, 32'(datamem_data), 32'd0);
    chk({tag, "_mr"}, 32'(ctr_datamem_MR), 32'd0);
    chk({tag, "_mw"}, 32'(ctr_datamem_MW), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    step(); step();
    chk_zero_outputs("reset");
    reset = 1'b0;

    // ADD with signed overflow and a read request
    drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 16'h1234, 1'b1, 1'b0);
    step();
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", 32'(overflow), 32'd1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_mr", 32'(ctr_datamem_MR), 32'd1);
    chk("add_mw", 32'(ctr_datamem_MW), 32'd0);
    chk("add_addr", 32'(datamem_address), 32'h000);
    chk("add_data", 32'(datamem_data), 32'h1234);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_mr", 32'(ctr_datamem_MR), 32'd0);
    chk("idle_result_hold", result, 32'h8000_0000);

    // SRA then SLT back to back
    drive(1'b1, 4'd8, 32'h8000_0000, 32'd4, 16'd0, 1'b0, 1'b0);
    step();
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_valid", 32'(out_valid), 32'd1);
    chk("sra_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 1'b0);
    step();
    chk("slt_result", result, 32'd1);
    chk("slt_valid", 32'(out_valid), 32'd1);

    // A few more ALU ops
    drive(1'b1, 4'd1, 32'h8000_0000, 32'd1, 16'd0, 1'b0, 1'b0);
    step();
    chk("sub_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(overflow), 32'd1);
    drive(1'b1, 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'd0, 1'b0, 1'b0);
    step();
    chk("xor_result", result, 32'hFF00_EDCB);
    chk("xor_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 4'd6, 32'd1, 32'd33, 16'd0, 1'b0, 1'b0);
    step();
    chk("sll_result", result, 32'd2);
    drive(1'b1, 4'd7, 32'h8000_0000, 32'd31, 16'd0, 1'b0, 1'b0);
    step();
    chk("srl_result", result, 32'd1);
    drive(1'b1, 4'd10, 32'd7, 32'hCAFE_F00D, 16'd0, 1'b0, 1'b0);
    step();
    chk("passb_result", result, 32'hCAFE_F00D);
    drive(1'b1, 4'd12, 32'd7, 32'd9, 16'd0, 1'b0, 1'b0);
    step();
    chk("op12_result", result, 32'd0);
    chk("op12_valid", 32'(out_valid), 32'd1);

    // Store with enable dropped for three cycles after accept
    drive(1'b1, 4'd0, 32'h10, 32'h5, 16'hBEEF, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("frz_valid", 32'(out_valid), 32'd1);
      chk("frz_addr", 32'(datamem_address), 32'h015);
      chk("frz_data", 32'(datamem_data), 32'hBEEF);
      chk("frz_mw", 32'(ctr_datamem_MW), 32'd1);
      chk("frz_mr", 32'(ctr_datamem_MR), 32'd0);
      step();
    end
    chk("frz_end_valid", 32'(out_valid), 32'd1);
    enable = 1'b1;
    step();
    chk("unfrz_valid", 32'(out_valid), 32'd0);
    chk("unfrz_mw", 32'(ctr_datamem_MW), 32'd0);
    chk("unfrz_addr_hold", 32'(datamem_address), 32'h015);

    // Conflicting read and write intent
    drive(1'b1, 4'd0, 32'd3, 32'd4, 16'h0A0A, 1'b1, 1'b1);
    step();
    chk("rw_result", result, 32'd7);
    chk("rw_mr", 32'(ctr_datamem_MR), 32'd0);
    chk("rw_mw", 32'(ctr_datamem_MW), 32'd0);

    // MUL -3 * 7; upstream keeps presenting an ADD that must be ignored
    drive(1'b1, 4'd9, 32'h0000_FFFD, 32'd7, 16'h55AA, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd0, 32'd1, 32'd1, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_valid", 32'(out_valid), 32'd0);
      step();
    end
    chk("mul_result", result, 32'hFFFF_FFEB);
    chk("mul_out_valid", 32'(out_valid), 32'd1);
    chk("mul_busy_done", 32'(busy), 32'd0);
    chk("mul_ready_done", 32'(in_ready), 32'd1);
    chk("mul_mr", 32'(ctr_datamem_MR), 32'd0);
    chk("mul_ovf", 32'(overflow), 32'd0);
    chk("mul_addr", 32'(datamem_address), 32'h7EB);
    chk("mul_data", 32'(datamem_data), 32'h55AA);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    step();
    chk("mul_pulse_end", 32'(out_valid), 32'd0);

    // MUL with a negative multiplier: 5 * -2
    drive(1'b1, 4'd9, 32'h1234_0005, 32'h0000_FFFE, 16'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    chk("mul2_result", result, 32'hFFFF_FFF6);
    chk("mul2_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of a multiply
    drive(1'b1, 4'd9, 32'd100, 32'd100, 16'h7777, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero_outputs("mid_rst");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end
    chk("post_rst_result", result, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
